pixie_fb_arbiter: RTL

Single-port frame-buffer arbiter for the Pixie video path. It shares one 1 KiB synchronous RAM between three requesters: the DMA write stream from the Pixie DMA front end, the video scanout reader, and a host/debug port (OSD or save-state access). Grants are fixed-priority with an anti-starvation boost for the host. All RAM-side outputs and responses are registered.

---
 rtl/pixie_fb_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pixie_fb_arbiter.sv
// rtl/pixie_fb_arbiter.sv - single-port frame-buffer arbiter: DMA write, scanout read, host read/write
module pixie_fb_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 8,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_wr_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {G_NONE, G_DMA, G_VID, G_HOST} grant_t;

    localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

    grant_t     grant;
    grant_t     grant_next;
    grant_t     tag2;
    logic       host_we_q;
    logic [7:0] wait_cnt;
    logic       boost;

    assign boost = (wait_cnt >= MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= G_NONE;
        end else begin
            grant <= grant_next;
        end
    end

    always_comb begin
        grant_next = G_NONE;
        if (dma_wr_en) begin
            grant_next = G_DMA;
        end else if (boost && host_req) begin
            grant_next = G_HOST;
        end else if (vid_req) begin
            grant_next = G_VID;
        end else if (host_req) begin
            grant_next = G_HOST;
        end
    end

    // Acks and write enable decode straight from the grant register, so they stay registered.
    always_comb begin
        vid_ack  = 1'b0;
        host_ack = 1'b0;
        ram_we   = 1'b0;
        case (grant)
            G_DMA:   ram_we = 1'b1;
            G_VID:   vid_ack = 1'b1;
            G_HOST: begin
                host_ack = 1'b1;
                ram_we   = host_we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            host_we_q  <= 1'b0;
            wait_cnt   <= '0;
            tag2       <= G_NONE;
            vid_valid  <= 1'b0;
            vid_data   <= '0;
            host_valid <= 1'b0;
            host_rdata <= '0;
        end else begin
            case (grant_next)
                G_DMA: begin
                    ram_addr  <= dma_addr;
                    ram_wdata <= dma_data;
                    host_we_q <= 1'b0;
                end
                G_VID: begin
                    ram_addr  <= vid_addr;
                    host_we_q <= 1'b0;
                end
                G_HOST: begin
                    ram_addr  <= host_addr;
                    host_we_q <= host_we;
                    if (host_we) begin
                        ram_wdata <= host_wdata;
                    end
                end
                default: ;
            endcase

            if (!host_req || grant_next == G_HOST) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            // Second tag stage lines up with ram_rdata; host writes carry no tag.
            if (grant == G_VID || (grant == G_HOST && !host_we_q)) begin
                tag2 <= grant;
            end else begin
                tag2 <= G_NONE;
            end

            vid_valid  <= (tag2 == G_VID);
            host_valid <= (tag2 == G_HOST);
            if (tag2 == G_VID) begin
                vid_data <= ram_rdata;
            end
            if (tag2 == G_HOST) begin
                host_rdata <= ram_rdata;
            end
        end
    end

endmodule
